// File: rtl/rc_adsr_poly.sv
// rc_adsr_poly: polyphonic one-pole ADSR envelope generator, one voice per clock through a shared 2-stage pipe.
// Optional feature macro: RC_ADSR_RETRIG_EN (gate rising edge in DECAY/SUSTAIN restarts ATTACK).
module rc_adsr_poly #(
    parameter int VOICES   = 8,
    parameter int TAU_BITS = 16,
    parameter int ENV_BITS = 24,
    parameter int VEL_BITS = 16,
    parameter int VIDX_W   = $clog2(VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [VOICES-1:0]   gate,
    input  logic                vel_wr,
    input  logic [VIDX_W-1:0]   vel_voice,
    input  logic [VEL_BITS-1:0] vel_data,
    input  logic [TAU_BITS-1:0] attack_tau,
    input  logic [TAU_BITS-1:0] decay_tau,
    input  logic [VEL_BITS-1:0] sustain_lvl,
    input  logic [TAU_BITS-1:0] release_tau,
    output logic                env_valid,
    output logic [VIDX_W-1:0]   env_voice,
    output logic [ENV_BITS-1:0] env_data,
    output logic [VOICES-1:0]   available,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;

    localparam int PAD = ENV_BITS - 2 - VEL_BITS;
    localparam int PW  = TAU_BITS + ENV_BITS + 2;
    localparam logic [ENV_BITS-1:0] ENV_ONE    = ENV_BITS'(64'd1 << (ENV_BITS - 2));
    localparam logic [ENV_BITS-1:0] ENV_ONE_M1 = ENV_BITS'((64'd1 << (ENV_BITS - 2)) - 64'd1);
    localparam logic [ENV_BITS-1:0] ENV_MAX    = ENV_BITS'((64'd1 << (ENV_BITS - 2)) - (64'd1 << (ENV_BITS - 6)));
    localparam logic [ENV_BITS-1:0] ENV_MIN    = ENV_BITS'(64'd1 << (ENV_BITS - 21));
    localparam logic signed [ENV_BITS:0] MIN_S = $signed({1'b0, ENV_MIN});

    adsr_state_t         state_mem [VOICES];
    logic [ENV_BITS-1:0] env_mem   [VOICES];
    logic [VEL_BITS-1:0] vel_mem   [VOICES];
`ifdef RC_ADSR_RETRIG_EN
    logic                gate_prev_mem [VOICES];
    logic                s1_gate_prev;
`endif

    // ---------------- sequencer ----------------
    logic              seq_busy;
    logic [VIDX_W-1:0] seq_cnt;
    logic              sweep_busy, tick_accept, issue_valid;
    logic [VIDX_W-1:0] issue_idx;
    logic              s1_valid;

    // A sweep counts as in progress until the last voice has left the pipe.
    assign sweep_busy  = seq_busy | s1_valid | env_valid;
    assign tick_accept = tick & ~sweep_busy;
    assign issue_valid = tick_accept | seq_busy;
    assign issue_idx   = seq_busy ? seq_cnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_busy <= 1'b0;
            seq_cnt  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (tick & sweep_busy)
                overrun <= 1'b1;
            if (tick_accept) begin
                seq_busy <= 1'b1;
                seq_cnt  <= VIDX_W'(1);
            end else if (seq_busy) begin
                if (seq_cnt == VIDX_W'(VOICES - 1)) begin
                    seq_busy <= 1'b0;
                    seq_cnt  <= '0;
                end else begin
                    seq_cnt <= seq_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1: read, select target/tau, delta ----------------
    adsr_state_t         cur_state;
    logic [ENV_BITS-1:0] cur_env, peak_raw, peak, sus_tgt, hold_tgt, sel_target;
    logic [TAU_BITS-1:0] sel_tau;
    logic signed [ENV_BITS:0] cur_delta;

    always_comb begin
        cur_state  = state_mem[issue_idx];
        cur_env    = env_mem[issue_idx];
        peak_raw   = ENV_BITS'(vel_mem[issue_idx]) << PAD;
        peak       = (peak_raw > ENV_MAX) ? ENV_MAX : peak_raw;
        sus_tgt    = ENV_BITS'(sustain_lvl) << PAD;
        hold_tgt   = (sus_tgt < peak) ? sus_tgt : peak;
        sel_target = '0;
        sel_tau    = '0;
        case (cur_state)
            ATTACK:          begin sel_target = ENV_ONE;  sel_tau = attack_tau;  end
            DECAY, SUSTAIN:  begin sel_target = hold_tgt; sel_tau = decay_tau;   end
            RELEASE:         begin sel_target = '0;       sel_tau = release_tau; end
            default:         begin sel_target = '0;       sel_tau = '0;          end
        endcase
        cur_delta = $signed({1'b0, sel_target}) - $signed({1'b0, cur_env});
    end

    logic [VIDX_W-1:0]        s1_idx;
    adsr_state_t              s1_state;
    logic [ENV_BITS-1:0]      s1_env, s1_peak, s1_target;
    logic [TAU_BITS-1:0]      s1_tau;
    logic signed [ENV_BITS:0] s1_delta;
    logic                     s1_gate;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid     <= 1'b0;
            s1_idx       <= '0;
            s1_state     <= IDLE;
            s1_env       <= '0;
            s1_peak      <= '0;
            s1_target    <= '0;
            s1_tau       <= '0;
            s1_delta     <= '0;
            s1_gate      <= 1'b0;
`ifdef RC_ADSR_RETRIG_EN
            s1_gate_prev <= 1'b0;
`endif
        end else begin
            s1_valid     <= issue_valid;
            s1_idx       <= issue_idx;
            s1_state     <= cur_state;
            s1_env       <= cur_env;
            s1_peak      <= peak;
            s1_target    <= sel_target;
            s1_tau       <= sel_tau;
            s1_delta     <= cur_delta;
            s1_gate      <= gate[issue_idx];
`ifdef RC_ADSR_RETRIG_EN
            s1_gate_prev <= gate_prev_mem[issue_idx];
`endif
        end
    end

    // ---------------- stage 2: multiply, add, saturate, next state ----------------
    logic signed [PW-1:0]       prod;
    logic signed [ENV_BITS+1:0] step, sum;
    logic [ENV_BITS-1:0]        env_sat, nxt_env;
    logic signed [ENV_BITS:0]   diff;
    logic                       near;
    adsr_state_t                nxt_state;

    always_comb begin
        prod    = PW'($signed({1'b0, s1_tau})) * PW'(s1_delta);
        step    = (ENV_BITS + 2)'(prod >>> TAU_BITS);
        sum     = $signed({2'b00, s1_env}) + step;
        if (sum[ENV_BITS+1])
            env_sat = '0;
        else if (sum > $signed({2'b00, ENV_ONE_M1}))
            env_sat = ENV_ONE_M1;
        else
            env_sat = sum[ENV_BITS-1:0];
        diff      = $signed({1'b0, env_sat}) - $signed({1'b0, s1_target});
        near      = (diff < MIN_S) && (diff > -MIN_S);
        nxt_state = s1_state;
        nxt_env   = env_sat;
        // Gate-driven transitions hold the envelope; the new state integrates from the next sweep.
        case (s1_state)
            IDLE: begin
                nxt_env = '0;
                if (s1_gate) nxt_state = ATTACK;
            end
            ATTACK: begin
                if (!s1_gate) begin
                    nxt_state = RELEASE;
                    nxt_env   = s1_env;
                end else if (env_sat >= s1_peak) begin
                    nxt_state = DECAY;
                    nxt_env   = s1_peak;
                end
            end
            DECAY, SUSTAIN: begin
                if (!s1_gate) begin
                    nxt_state = RELEASE;
                    nxt_env   = s1_env;
`ifdef RC_ADSR_RETRIG_EN
                end else if (!s1_gate_prev) begin
                    nxt_state = ATTACK;
                    nxt_env   = s1_env;
`endif
                end else if (near) begin
                    nxt_state = SUSTAIN;
                    nxt_env   = s1_target;
                end
            end
            RELEASE: begin
                if (env_sat < ENV_MIN) begin
                    nxt_state = IDLE;
                    nxt_env   = '0;
                end else if (s1_gate) begin
                    nxt_state = ATTACK;
                    nxt_env   = s1_env;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_env   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_valid <= 1'b0;
            env_voice <= '0;
            env_data  <= '0;
        end else begin
            env_valid <= s1_valid;
            if (s1_valid) begin
                env_voice <= s1_idx;
                env_data  <= nxt_env;
            end
        end
    end

    // ---------------- per-voice storage ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VOICES; v++) begin
                state_mem[v]     <= IDLE;
                env_mem[v]       <= '0;
                vel_mem[v]       <= '0;
`ifdef RC_ADSR_RETRIG_EN
                gate_prev_mem[v] <= 1'b0;
`endif
            end
        end else begin
            if (vel_wr)
                vel_mem[vel_voice] <= vel_data;
            if (s1_valid) begin
                state_mem[s1_idx]     <= nxt_state;
                env_mem[s1_idx]       <= nxt_env;
`ifdef RC_ADSR_RETRIG_EN
                gate_prev_mem[s1_idx] <= s1_gate;
`endif
            end
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_avail
        assign available[gi] = (state_mem[gi] == IDLE);
    end

endmodule
